// File: rtl/cart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cart_loader
//  Description : Cartridge-RAM load controller. Owns the cartridge-RAM write
//                port and fills it from one of three sources: a custom HPS
//                download, a built-in cartridge copied out of the pack ROM,
//                or the empty-cartridge value 0xFF. Holds the system CPU in
//                reset while the cartridge contents are changing.
//  Revision    : 1.0  initial release
// ============================================================================
module cart_loader #(
  parameter int CART_AW        = 14,
  parameter int PACK_AW        = 18,
  parameter int NUM_CARTS      = 10,
  parameter int RELEASE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         cartridge_select,
  input  logic               dn_download,
  input  logic [7:0]         dn_index,
  input  logic [15:0]        dn_addr,
  input  logic [7:0]         dn_data,
  input  logic               dn_wr,
  output logic [PACK_AW-1:0] pack_addr,
  input  logic [7:0]         pack_data,
  output logic [CART_AW-1:0] cart_addr,
  output logic [7:0]         cart_data,
  output logic               cart_we,
  output logic               cart_present,
  output logic               hold_reset,
  output logic               busy
);

  // The counter must reach N (one past the last byte) during a copy.
  localparam int CNT_W = CART_AW + 1;
  localparam logic [CNT_W-1:0] CART_BYTES = {1'b1, {CART_AW{1'b0}}};
  localparam logic [CNT_W-1:0] LAST_BYTE  = CART_BYTES - CNT_W'(1);
  localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [3:0]       MAX_SEL    = 4'(NUM_CARTS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COPY    = 3'd1,
    S_FILL    = 3'd2,
    S_DL      = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t           state;
  logic [3:0]       sel_q;
  logic [CNT_W-1:0] counter;
  logic             dl_q;
  logic             dl_flag;

  logic             dl_start;
  logic             dl_end;
  logic             sel_chg;
  logic             sel_builtin;
  logic             dl_in_range;
  logic [CNT_W-1:0] cnt_next;
  logic [PACK_AW-1:0] sel_base;
  logic [PACK_AW-1:0] copy_base;

  assign dl_start    = dn_download & ~dl_q & (dn_index == 8'd1);
  assign dl_end      = ~dn_download & dl_q;
  assign sel_chg     = (cartridge_select != sel_q);
  assign sel_builtin = (cartridge_select != 4'd0) && (cartridge_select <= MAX_SEL);
  // Bytes beyond the cartridge window are silently dropped.
  assign dl_in_range = ((dn_addr >> CART_AW) == 16'd0);
  assign cnt_next    = counter + CNT_W'(1);
  // Cartridge k (1-based) lives at (k-1)*N in the pack ROM.
  assign sel_base    = PACK_AW'({cartridge_select - 4'd1, {CART_AW{1'b0}}});
  assign copy_base   = PACK_AW'({sel_q - 4'd1, {CART_AW{1'b0}}});

  // Load-control state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      sel_q        <= 4'd0;
      counter      <= '0;
      dl_q         <= 1'b0;
      dl_flag      <= 1'b0;
      pack_addr    <= '0;
      cart_addr    <= '0;
      cart_data    <= 8'd0;
      cart_we      <= 1'b0;
      cart_present <= 1'b0;
      hold_reset   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      dl_q    <= dn_download;
      // Write strobe is a single-cycle pulse unless a state re-asserts it.
      cart_we <= 1'b0;

      if (state == S_DL) begin
        // Selection changes are absorbed so the download is not overwritten.
        sel_q <= cartridge_select;
        if (dl_end) begin
          state        <= S_RELEASE;
          counter      <= '0;
          cart_present <= dl_flag;
        end else if (dn_wr && dl_in_range) begin
          cart_we   <= 1'b1;
          cart_addr <= dn_addr[CART_AW-1:0];
          cart_data <= dn_data;
          dl_flag   <= 1'b1;
        end
      end else if (dl_start) begin
        // A custom download pre-empts anything else in progress.
        state        <= S_DL;
        counter      <= '0;
        dl_flag      <= 1'b0;
        cart_present <= 1'b0;
        hold_reset   <= 1'b1;
        busy         <= 1'b1;
      end else if (sel_chg) begin
        // New selection: (re)start the load from byte 0.
        sel_q      <= cartridge_select;
        counter    <= '0;
        hold_reset <= 1'b1;
        busy       <= 1'b1;
        if (sel_builtin) begin
          state     <= S_COPY;
          pack_addr <= sel_base;
        end else begin
          state     <= S_FILL;
          cart_we   <= 1'b1;
          cart_addr <= '0;
          cart_data <= 8'hFF;
        end
      end else begin
        case (state)
          S_COPY: begin
            // ROM data for counter-1 is written while address counter is out.
            if (counter == CART_BYTES) begin
              state        <= S_RELEASE;
              counter      <= '0;
              cart_present <= 1'b1;
            end else begin
              cart_we   <= 1'b1;
              cart_addr <= counter[CART_AW-1:0];
              cart_data <= pack_data;
              counter   <= cnt_next;
              if (cnt_next != CART_BYTES) begin
                pack_addr <= copy_base + PACK_AW'(cnt_next);
              end
            end
          end
          S_FILL: begin
            if (counter == LAST_BYTE) begin
              state        <= S_RELEASE;
              counter      <= '0;
              cart_present <= 1'b0;
            end else begin
              cart_we   <= 1'b1;
              cart_addr <= cnt_next[CART_AW-1:0];
              cart_data <= 8'hFF;
              counter   <= cnt_next;
            end
          end
          S_RELEASE: begin
            if (counter == REL_LAST) begin
              state      <= S_IDLE;
              counter    <= '0;
              hold_reset <= 1'b0;
              busy       <= 1'b0;
            end else begin
              counter <= cnt_next;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cart_loader
//  Description : Self-checking bench for cart_loader: table of full loads,
//                selection restart, downloads, and reset during a fill.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cart_loader;

  localparam int N = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cartridge_select;
  logic        dn_download;
  logic [7:0]  dn_index;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [17:0] pack_addr;
  logic [7:0]  pack_data;
  logic [13:0] cart_addr;
  logic [7:0]  cart_data;
  logic        cart_we;
  logic        cart_present;
  logic        hold_reset;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Pack ROM contents: a fixed hash of the address.
  function automatic logic [7:0] rom_fn(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ {a[17:13], 3'b101};
  endfunction

  // Read data follows the registered ROM address.
  assign pack_data = rom_fn(pack_addr);

  cart_loader #(
    .CART_AW(14), .PACK_AW(18), .NUM_CARTS(10), .RELEASE_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .cartridge_select(cartridge_select),
    .dn_download(dn_download), .dn_index(dn_index), .dn_addr(dn_addr),
    .dn_data(dn_data), .dn_wr(dn_wr), .pack_addr(pack_addr),
    .pack_data(pack_data), .cart_addr(cart_addr), .cart_data(cart_data),
    .cart_we(cart_we), .cart_present(cart_present),
    .hold_reset(hold_reset), .busy(busy)
  );

  typedef struct {
    logic [3:0]  sel;
    logic        is_copy;
    logic [17:0] base;
    int          exp_hold;
    int          exp_first;
    logic        exp_present;
  } load_vec_t;

  load_vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Walk a load from the current negedge until hold_reset falls, checking
  // every write against the expected sequential address and data.
  task automatic measure(input logic is_copy, input logic [17:0] base,
                         output int hold_cnt, output int wr_cnt, output int bad,
                         output int first, output logic [17:0] pmin,
                         output logic [17:0] pmax);
    logic [7:0]  exp_d;
    logic [17:0] off;
    hold_cnt = 0; wr_cnt = 0; bad = 0; first = -1;
    pmin = '1; pmax = '0;
    while (hold_reset && hold_cnt < 40000) begin
      if (cart_we) begin
        if (first < 0) first = hold_cnt;
        off   = 18'(wr_cnt);
        exp_d = is_copy ? rom_fn(base + off) : 8'hFF;
        if (cart_addr != off[13:0] || cart_data != exp_d) bad++;
        wr_cnt++;
      end
      if (pack_addr < pmin) pmin = pack_addr;
      if (pack_addr > pmax) pmax = pack_addr;
      hold_cnt++;
      step();
    end
    if (hold_cnt >= 40000) check("load_timeout", 32'(hold_cnt), 32'd0);
  endtask

  initial begin
    int hold_cnt, wr_cnt, bad, first, we_cnt;
    logic [17:0] pmin, pmax;

    vecs[0] = '{sel: 4'd3,  is_copy: 1'b1, base: 18'h08000, exp_hold: N + 1 + 8, exp_first: 1, exp_present: 1'b1};
    vecs[1] = '{sel: 4'd0,  is_copy: 1'b0, base: 18'h00000, exp_hold: N + 8,     exp_first: 0, exp_present: 1'b0};
    vecs[2] = '{sel: 4'd12, is_copy: 1'b0, base: 18'h00000, exp_hold: N + 8,     exp_first: 0, exp_present: 1'b0};

    reset = 1'b1; cartridge_select = 4'd0; dn_download = 1'b0; dn_index = 8'd0;
    dn_addr = 16'd0; dn_data = 8'd0; dn_wr = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (5) step();
    // Reset state with selection 0 must stay idle with all outputs low.
    check("rst_outputs", {pack_addr, cart_addr}, 32'd0);
    check("rst_data", {cart_data, cart_we, cart_present, hold_reset, busy}, 32'd0);

    // Table of complete loads.
    for (int i = 0; i < 3; i++) begin
      cartridge_select = vecs[i].sel;
      step();
      check($sformatf("v%0d_hold_rise", i), hold_reset, 1);
      measure(vecs[i].is_copy, vecs[i].base, hold_cnt, wr_cnt, bad, first, pmin, pmax);
      check($sformatf("v%0d_hold_cycles", i), hold_cnt, vecs[i].exp_hold);
      check($sformatf("v%0d_writes", i), wr_cnt, N);
      check($sformatf("v%0d_bad_writes", i), bad, 0);
      check($sformatf("v%0d_first_write", i), first, vecs[i].exp_first);
      check($sformatf("v%0d_present", i), cart_present, vecs[i].exp_present);
      check($sformatf("v%0d_busy_after", i), busy, 0);
      if (vecs[i].is_copy) begin
        check($sformatf("v%0d_pack_min", i), pmin, vecs[i].base);
        check($sformatf("v%0d_pack_max", i), pmax, vecs[i].base + 18'(N - 1));
      end
      repeat (3) step();
    end

    // Selection 2 -> 5 while the copy counter is at 100.
    cartridge_select = 4'd2;
    step();
    repeat (100) step();
    cartridge_select = 4'd5;
    step();
    check("restart_pack_addr", pack_addr, 18'h10000);
    measure(1'b1, 18'h10000, hold_cnt, wr_cnt, bad, first, pmin, pmax);
    check("restart_total_hold", 101 + hold_cnt, 101 + N + 1 + 8);
    check("restart_writes", wr_cnt, N);
    check("restart_bad_writes", bad, 0);
    check("restart_pack_max", pmax, 18'h13FFF);
    check("restart_present", cart_present, 1);
    repeat (3) step();

    // dn_index 0 download while idle is ignored completely.
    dn_index = 8'd0; dn_download = 1'b1;
    we_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      dn_wr = (i % 2 == 0); dn_addr = 16'(i); dn_data = 8'(i);
      step();
      if (cart_we || busy) we_cnt++;
    end
    dn_wr = 1'b0; dn_download = 1'b0;
    step(); step();
    check("idx0_no_activity", we_cnt + 32'(busy), 0);

    // dn_index 1 download mid-copy aborts the copy.
    cartridge_select = 4'd7;
    repeat (50) step();
    dn_index = 8'd1; dn_download = 1'b1;
    step();
    check("dl_entry", {busy, hold_reset, cart_present, cart_we}, 4'b1100);
    step();
    check("dl_no_copy_write", cart_we, 0);
    cartridge_select = 4'd4;
    dn_wr = 1'b1; dn_addr = 16'h0000; dn_data = 8'hA5;
    step();
    dn_wr = 1'b0;
    check("dl_wr0", {cart_we, 2'b00, cart_addr, cart_data}, {1'b1, 2'b00, 14'h0000, 8'hA5});
    step();
    check("dl_wr0_pulse", cart_we, 0);
    dn_wr = 1'b1; dn_addr = 16'h3FFF; dn_data = 8'h5A;
    step();
    dn_wr = 1'b0;
    check("dl_wr1", {cart_we, 2'b00, cart_addr, cart_data}, {1'b1, 2'b00, 14'h3FFF, 8'h5A});
    step();
    dn_wr = 1'b1; dn_addr = 16'h4000; dn_data = 8'h11;
    step();
    dn_wr = 1'b0;
    check("dl_drop_oob", cart_we, 0);
    step();
    dn_download = 1'b0;
    step();
    check("dl_end_present", {cart_present, hold_reset, cart_we}, 3'b110);
    we_cnt = 0; hold_cnt = 0;
    while (hold_reset && hold_cnt < 100) begin
      if (cart_we) we_cnt++;
      hold_cnt++;
      step();
    end
    check("dl_release_len", hold_cnt, 8);
    check("dl_release_no_we", we_cnt, 0);
    repeat (5) step();
    check("dl_not_overwritten", {busy, cart_present}, 2'b01);

    // Reset in the middle of a fill.
    cartridge_select = 4'd0;
    repeat (20) step();
    check("fill_active", cart_we, 1);
    reset = 1'b1;
    step();
    check("rst_fill_we", cart_we, 0);
    check("rst_fill_outputs", {pack_addr, cart_addr}, 32'd0);
    check("rst_fill_flags", {cart_data, cart_present, hold_reset, busy}, 32'd0);
    step();
    reset = 1'b0;
    repeat (5) step();
    check("rst_fill_idle", {busy, cart_we}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cart_loader.md
# cart_loader

Cartridge-RAM load controller between the HPS download path, the built-in cartridge pack ROM and the system's cartridge RAM. It owns the single cartridge-RAM write port. It arbitrates between three sources: a user cartridge download, a copy of the menu-selected built-in cartridge from the pack ROM, and a fill with the empty-cartridge value. It also holds the system CPU in reset while the cartridge contents change.

## Interface
- CART_AW, 14: cartridge address width (N = 2^CART_AW bytes per cartridge).
- PACK_AW, 18: pack ROM address width; must be ≥ CART_AW+4.
- NUM_CARTS, 10: number of built-in cartridges in the pack.
- RELEASE_CYCLES, 8: reset-hold tail after a load completes.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cartridge_select  in  4  OSD cartridge choice: 0 = empty, 1..NUM_CARTS = built-in, others = empty.
- dn_download  in  1  HPS download active.
- dn_index  in  8  download target: 0 = BIOS (ignored here), 1 = custom cartridge.
- dn_addr  in  16  download byte address.
- dn_data  in  8  download byte.
- dn_wr  in  1  download byte strobe, one cycle.
- pack_addr  out  PACK_AW  pack ROM address; ROM data is valid one cycle later.
- pack_data  in  8  pack ROM data.
- cart_addr  out  CART_AW  cartridge RAM write address.
- cart_data  out  8  cartridge RAM write data.
- cart_we  out  1  cartridge RAM write enable, sampled by RAM on the next edge.
- cart_present  out  1  cartridge RAM holds a valid image.
- hold_reset  out  1  system CPU reset request.
- busy  out  1  state ≠ IDLE.

## Operation
- All outputs are registered.
- Reset values:
  - state = IDLE; sel_q = 0; counter = 0.
  - pack_addr, cart_addr, cart_data = 0.
  - cart_we, cart_present, hold_reset, busy = 0.
- Edge detection: dn_download is registered as dl_q.
  - dl_start = dn_download & ~dl_q & (dn_index == 1).
  - dl_end = ~dn_download & dl_q.
  - sel_chg = (cartridge_select ≠ sel_q).
- States:
  - IDLE
    - dl_start → DL. This has priority over sel_chg.
    - Otherwise sel_chg → latch sel_q = cartridge_select and clear the counter. If the selection is 1..NUM_CARTS, go to COPY; otherwise go to FILL.
  - COPY
    - pack_addr = (sel_q−1)·N + counter.
    - In the following cycle: cart_we = 1, cart_addr = counter−1, cart_data = pack_data.
    - The counter runs 0..N. N writes are made in total.
    - On the last write → RELEASE, with cart_present = 1.
  - FILL
    - cart_we = 1, cart_data = 0xFF, cart_addr = counter, for counter 0..N−1.
    - On the last write → RELEASE, with cart_present = 0.
  - DL
    - cart_present is cleared on entry.
    - Each dn_wr with dn_addr < N → one cycle later: cart_we = 1, cart_addr = dn_addr[CART_AW−1:0], cart_data = dn_data. A flag is set.
    - A dn_wr with dn_addr ≥ N is dropped.
    - On dl_end → RELEASE, with cart_present = flag.
    - sel_q is set to cartridge_select so the download is not overwritten.
  - RELEASE
    - Counts RELEASE_CYCLES cycles, then → IDLE.
- hold_reset = 1 in every state except IDLE.
- Preemption:
  - dl_start in COPY, FILL or RELEASE → abort, go to DL. The remaining writes are not made.
  - sel_chg in COPY, FILL or RELEASE → restart with the new selection from counter 0.
  - sel_chg during DL is ignored. sel_q still tracks cartridge_select.
- dn_index 0 downloads are ignored entirely: no state change and no writes.
- reset during any state → reset values, with the load abandoned. A nonzero cartridge_select then retriggers COPY through sel_chg.

## Timing
- COPY: entered at cycle 0, first write at cycle 1, last write at cycle N. RELEASE then starts, and hold_reset falls RELEASE_CYCLES cycles later.
- FILL: N write cycles, then RELEASE.
- From the sel_chg edge to hold_reset rising: 1 cycle.
- DL write latency: 1 cycle from dn_wr to cart_we.
- cart_we is never asserted in IDLE or RELEASE.
- Only one source drives the write port in any cycle.

## Test plan
- Reset with cartridge_select = 0:
  - All outputs are 0 and the state stays IDLE.
  - Raise cartridge_select to 3: pack_addr steps 0x8000..0xBFFF, and the writes reach cart_addr 0..0x3FFF with cart_data matching the ROM.
  - hold_reset is high for 16385+8 cycles; cart_present is 1 afterwards.
- Select 0 after a loaded cartridge:
  - 16384 writes of 0xFF, then cart_present = 0.
  - cartridge_select = 12 behaves identically.
- Custom download (dn_index = 1):
  - Write bytes at 0x0000 = 0xA5, 0x3FFF = 0x5A and 0x4000 = 0x11.
  - Exactly two writes occur, each one cycle after its strobe; the 0x4000 byte is dropped.
  - After dn_download falls: cart_present = 1 and hold_reset falls 8 cycles later.
- Change the selection 2 → 5 at copy counter 100:
  - COPY restarts with pack_addr = 0x10000.
  - Total hold ≥ 100 + 16385 + 8 cycles.
- Start a dn_index = 0 download while IDLE: no cart_we and busy stays 0. Start a dn_index = 1 download mid-COPY: the copy aborts and only download writes follow.
- Assert reset mid-FILL: cart_we drops the next cycle and all outputs return to their reset values.
